x2050_ls_arb: RTL

Local-storage access arbiter for the 2050 CPU. It sits in front of the 64 x 32 single-port local storage and lets two secondary requesters share it with the microcode datapath: the channel (port 0) and the console manual controls (port 1). It steals LS cycles by holding the ROS sequencer, performs one read or write per grant, and returns read data with a one-cycle acknowledge. Otherwise it passes the CPU's LS controls straight through.

---
 rtl/x2050_ls_arb.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/x2050_ls_arb.sv
// ----------------------------------------------------------------------------
// x2050_ls_arb
//
// Local-storage access arbiter for the 2050 CPU. The channel (port 0) and the
// console manual controls (port 1) share the 64 x 32 single-port local storage
// with the microcode datapath. A granted requester first stops the ROS
// sequencer, then gets exactly one LS cycle for a read or a write, and then
// receives a one-cycle acknowledge. While no grant owns LS, the CPU's LS
// controls pass straight through to local storage.
//
// Ports
//   i_clk          sole clock
//   i_reset        asynchronous, active-low reset
//   i_ros_advance  CPU microcode advance strobe
//   i_cpu_we       CPU LS write enable
//   i_cpu_lsa      CPU LS address
//   i_cpu_data     CPU LS write data
//   i_ros_held     ROS sequencer has stopped in answer to o_ros_hold
//   i_req[1:0]     per-port request (0 = channel, 1 = console)
//   i_wr[1:0]      per-port write(1)/read(0), stable while requesting
//   i_addr0/1      per-port LS address
//   i_wdata0/1     per-port write data
//   o_ack[1:0]     one-cycle grant-complete pulse per port
//   o_rdata        registered read data
//   o_ros_hold     request to the ROS sequencer to stop advancing
//   o_err          sticky flag: CPU advanced while the arbiter owned LS
//   o_ls_lsa       address to local storage
//   o_ls_we        write enable to local storage
//   o_ls_newvalue  write data to local storage
//   o_ls_advance   write strobe to local storage
//   i_ls           LS read data, combinational from o_ls_lsa
// ----------------------------------------------------------------------------
module x2050_ls_arb (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ros_advance,
    input  logic        i_cpu_we,
    input  logic [5:0]  i_cpu_lsa,
    input  logic [31:0] i_cpu_data,
    input  logic        i_ros_held,
    input  logic [1:0]  i_req,
    input  logic [1:0]  i_wr,
    input  logic [5:0]  i_addr0,
    input  logic [5:0]  i_addr1,
    input  logic [31:0] i_wdata0,
    input  logic [31:0] i_wdata1,
    output logic [1:0]  o_ack,
    output logic [31:0] o_rdata,
    output logic        o_ros_hold,
    output logic        o_err,
    output logic [5:0]  o_ls_lsa,
    output logic        o_ls_we,
    output logic [31:0] o_ls_newvalue,
    output logic        o_ls_advance,
    input  logic [31:0] i_ls
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        ACCESS = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic        rr_reg;        // last-served port
    logic        port_reg;      // port owning the current grant
    logic        wr_reg;
    logic [5:0]  addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic        win_port;
    logic        win_wr;
    logic [5:0]  win_addr;
    logic [31:0] win_wdata;

    // Round robin: a lone requester wins outright; on a tie the port that
    // was not served last wins. rr resets to 1 so the channel wins the
    // first tie.
    always_comb begin
        win_port = 1'b0;
        case (i_req)
            2'b01:   win_port = 1'b0;
            2'b10:   win_port = 1'b1;
            default: win_port = ~rr_reg;
        endcase
    end

    assign win_wr    = win_port ? i_wr[1]  : i_wr[0];
    assign win_addr  = win_port ? i_addr1  : i_addr0;
    assign win_wdata = win_port ? i_wdata1 : i_wdata0;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|i_req) state_next = HOLD;
            HOLD:    if (i_ros_held) state_next = ACCESS;
            ACCESS:  state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // During ACCESS the arbiter owns LS outright; a CPU advance in that
    // cycle is ignored here and only recorded in o_err.
    always_comb begin
        o_ros_hold    = 1'b0;
        o_ls_lsa      = i_cpu_lsa;
        o_ls_we       = i_cpu_we;
        o_ls_newvalue = i_cpu_data;
        o_ls_advance  = i_ros_advance;
        case (state_reg)
            HOLD: begin
                o_ros_hold = 1'b1;
            end
            ACCESS: begin
                o_ros_hold    = 1'b1;
                o_ls_lsa      = addr_reg;
                o_ls_we       = wr_reg;
                o_ls_newvalue = wdata_reg;
                o_ls_advance  = 1'b1;
            end
            default: begin
                o_ros_hold = 1'b0;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            assign o_ack[gi] = (state_reg == ACK) && (port_reg == 1'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Grant datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rr_reg    <= 1'b1;
            port_reg  <= 1'b0;
            wr_reg    <= 1'b0;
            addr_reg  <= 6'd0;
            wdata_reg <= 32'd0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|i_req) begin
                        port_reg  <= win_port;
                        wr_reg    <= win_wr;
                        addr_reg  <= win_addr;
                        wdata_reg <= win_wdata;
                    end
                end
                ACCESS: begin
                    if (!wr_reg) rdata_reg <= i_ls;
                    if (i_ros_advance) err_reg <= 1'b1;
                end
                ACK: begin
                    rr_reg <= port_reg;
                end
                default: begin
                    rr_reg <= rr_reg;
                end
            endcase
        end
    end

    assign o_rdata = rdata_reg;
    assign o_err   = err_reg;

endmodule
